// File: rtl/l1c_axi_master_pkg.sv
// Shared definitions for the L1 cache AXI master.
// Holds the cache access-type encodings, the data width, the AXI constants driven on the
// address channels, and the master FSM state type.
package l1c_axi_master_pkg;

    localparam int unsigned DATA_BITS = 32;

    // Cache access-type encodings carried on mem_type.
    localparam logic [2:0] CACHE_BYTE    = 3'd0;
    localparam logic [2:0] CACHE_HWORD   = 3'd1;
    localparam logic [2:0] CACHE_WORD    = 3'd2;
    localparam logic [2:0] CACHE_BYTE_U  = 3'd4;
    localparam logic [2:0] CACHE_HWORD_U = 3'd5;

    // AXI constants.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [3:0] AXI_LEN_LINE   = 4'd3;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [3:0] AXI_ID         = 4'h0;

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRdata,
        StWaddr,
        StWresp
    } state_e;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Write-lane formatter: turns a cache store (type, low address bits, data) into the AXI write
// strobe and lane-replicated write data.
// Ports:
//   type_i    - cache access type (CACHE_* encoding)
//   addr_lo_i - byte address bits [1:0]
//   data_i    - store data, right-aligned
//   wstrb_o   - byte strobe for the 32-bit bus
//   wdata_o   - store data replicated across all lanes
module axi_wstrb_gen
    import l1c_axi_master_pkg::*;
(
    input  logic [2:0]           type_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic [3:0]           wstrb_o,
    output logic [DATA_BITS-1:0] wdata_o
);

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = data_i;
        case (type_i)
            CACHE_BYTE, CACHE_BYTE_U: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{data_i[7:0]}};
            end
            CACHE_HWORD, CACHE_HWORD_U: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{data_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/l1c_axi_master.sv
// L1 cache to AXI3-style master bridge.
// Reads fetch a 4-beat INCR line burst and hand each beat to the cache as it arrives; writes
// issue a single-beat INCR store with lane strobes.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   mem_req/mem_write/...   - cache request side; mem_out/mem_wait report beats and completion
//   AR*/R*                  - AXI read address and read data channels
//   AW*/W*/B*               - AXI write address, write data and write response channels
module l1c_axi_master
    import l1c_axi_master_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    // Cache side
    input  logic                 mem_req,
    input  logic                 mem_write,
    input  logic [31:0]          mem_addr,
    input  logic [DATA_BITS-1:0] mem_in,
    input  logic [2:0]           mem_type,
    output logic [DATA_BITS-1:0] mem_out,
    output logic                 mem_wait,
    // AXI read address
    output logic [3:0]           ARID,
    output logic [31:0]          ARADDR,
    output logic [3:0]           ARLEN,
    output logic [2:0]           ARSIZE,
    output logic [1:0]           ARBURST,
    output logic                 ARVALID,
    input  logic                 ARREADY,
    // AXI read data
    input  logic [3:0]           RID,
    input  logic [DATA_BITS-1:0] RDATA,
    input  logic [1:0]           RRESP,
    input  logic                 RLAST,
    input  logic                 RVALID,
    output logic                 RREADY,
    // AXI write address
    output logic [3:0]           AWID,
    output logic [31:0]          AWADDR,
    output logic [3:0]           AWLEN,
    output logic [2:0]           AWSIZE,
    output logic [1:0]           AWBURST,
    output logic                 AWVALID,
    input  logic                 AWREADY,
    // AXI write data
    output logic [DATA_BITS-1:0] WDATA,
    output logic [3:0]           WSTRB,
    output logic                 WLAST,
    output logic                 WVALID,
    input  logic                 WREADY,
    // AXI write response
    input  logic [3:0]           BID,
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
    output logic                 BREADY
);

    state_e               state_q;
    logic [31:0]          addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic [2:0]           type_q;
    logic [1:0]           beat_q;
    logic                 aw_done_q;
    logic                 w_done_q;
    logic                 arvalid_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 rready_q;
    logic                 bready_q;

    logic aw_fin;
    logic w_fin;

    // Response IDs and status codes are not used: one outstanding transaction, errors ignored.
    logic unused_axi;
    assign unused_axi = ^{RID, RRESP, BID, BRESP};

    // A channel counts as finished once it handshook now or in an earlier cycle.
    assign aw_fin = aw_done_q | (awvalid_q & AWREADY);
    assign w_fin  = w_done_q  | (wvalid_q  & WREADY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            data_q    <= '0;
            type_q    <= '0;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_req) begin
                        addr_q <= mem_addr;
                        if (mem_write) begin
                            data_q    <= mem_in;
                            type_q    <= mem_type;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWaddr;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StRaddr;
                        end
                    end
                end
                StRaddr: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= '0;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    if (RVALID) begin
                        beat_q <= beat_q + 2'd1;
                        // Early RLAST ends the burst just like the fourth beat does.
                        if (RLAST || beat_q == 2'd3) begin
                            beat_q   <= '0;
                            rready_q <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
                StWaddr: begin
                    if (awvalid_q && AWREADY) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && WREADY) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= StWresp;
                    end
                end
                StWresp: begin
                    if (BVALID) begin
                        bready_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Beat and completion strobes are combinational so data reaches the cache with no delay.
    always_comb begin
        mem_wait = 1'b1;
        case (state_q)
            StIdle:  mem_wait = mem_req;
            StRdata: mem_wait = ~RVALID;
            StWresp: mem_wait = ~BVALID;
            default: mem_wait = 1'b1;
        endcase
    end

    assign mem_out = (state_q == StRdata && RVALID) ? RDATA : '0;

    assign ARID    = AXI_ID;
    assign ARADDR  = {addr_q[31:4], 4'b0000};
    assign ARLEN   = AXI_LEN_LINE;
    assign ARSIZE  = AXI_SIZE_WORD;
    assign ARBURST = AXI_BURST_INCR;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

    assign AWID    = AXI_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = AXI_LEN_SINGLE;
    assign AWSIZE  = AXI_SIZE_WORD;
    assign AWBURST = AXI_BURST_INCR;
    assign AWVALID = awvalid_q;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

    axi_wstrb_gen u_wstrb_gen (
        .type_i    (type_q),
        .addr_lo_i (addr_q[1:0]),
        .data_i    (data_q),
        .wstrb_o   (WSTRB),
        .wdata_o   (WDATA)
    );

endmodule

// File: tb/tb_l1c_axi_master.sv
// Testbench for l1c_axi_master: the bench plays the AXI slave with directed timing, pushes the
// expected cache-side beats/completions into a scoreboard as it drives them, and a monitor
// pops and compares every cycle in which the DUT drops mem_wait during a transaction.
module tb_l1c_axi_master;
    import l1c_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_write;
    logic [31:0] mem_addr, mem_in;
    logic [2:0]  mem_type;
    logic [31:0] mem_out;
    logic        mem_wait;
    logic [3:0]  ARID, ARLEN, AWID, AWLEN;
    logic [31:0] ARADDR, AWADDR;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, ARREADY, AWVALID, AWREADY;
    logic [3:0]  RID, BID;
    logic [31:0] RDATA, WDATA;
    logic [1:0]  RRESP, BRESP;
    logic        RLAST, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic        BVALID, BREADY;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic active = 1'b0;

    always #5 clk = ~clk;

    l1c_axi_master dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .mem_type  (mem_type),
        .mem_out   (mem_out),
        .mem_wait  (mem_wait),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RID       (RID),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every mem_wait=0 cycle inside a transaction must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (active && !rst && mem_wait === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_mem_wait_low", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.rd) begin
                        chk("rd_beat_data", mem_out, e.data);
                        chk("rd_beat_rvalid", {31'b0, RVALID}, 32'd1);
                    end else begin
                        chk("wr_done_on_bvalid", {31'b0, BVALID}, 32'd1);
                    end
                end
            end
        end
    end

    task automatic idle_check(input string name);
        @(negedge clk);
        chk(name, {27'b0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_write = wr; mem_addr = a; mem_in = d; mem_type = t;
        active = 1'b1;
        @(negedge clk);
        chk("idle_req_wait_high", {31'b0, mem_wait}, 32'd1);
        @(posedge clk); #1;
        // Garbage after acceptance must be ignored.
        mem_req = 1'b0; mem_write = 1'b0; mem_addr = 32'hDEAD_BEEF; mem_in = 32'h1111_2222;
        mem_type = CACHE_WORD;
    endtask

    // vpat: RVALID per slot, LSB first. rlast_idx: beat carrying RLAST (>3 = none).
    // rst_after: assert reset after this many beats (<0 = never).
    task automatic do_read(input logic [31:0] a, input int ar_dly, input logic stray,
                           input logic [15:0] vpat, input int nslots, input logic [127:0] beats,
                           input int rlast_idx, input int rst_after);
        int   idx;
        logic done;
        issue(1'b0, a, 32'h0, CACHE_WORD);
        for (int c = 0; c <= ar_dly; c++) begin
            ARREADY = (c == ar_dly);
            RVALID  = stray && (c < ar_dly);
            RDATA   = 32'hBAD0_0000;
            @(negedge clk);
            chk("arvalid_held", {31'b0, ARVALID}, 32'd1);
            chk("rready_low_in_raddr", {31'b0, RREADY}, 32'd0);
            if (c == ar_dly) begin
                chk("araddr", ARADDR, {a[31:4], 4'b0});
                chk("ar_len_size_burst_id", {19'b0, ARLEN, ARSIZE, ARBURST, ARID},
                    {19'b0, 4'd3, 3'b010, 2'b01, 4'h0});
            end
            @(posedge clk); #1;
        end
        ARREADY = 1'b0; RVALID = 1'b0;
        idx = 0; done = 1'b0;
        for (int s = 0; s < nslots && !done; s++) begin
            RVALID = vpat[s];
            RDATA  = vpat[s] ? beats[idx*32 +: 32] : 32'h0;
            RLAST  = vpat[s] && (idx == rlast_idx);
            RRESP  = (idx == 1) ? 2'b10 : 2'b00;
            if (vpat[s]) sb.push_back('{1'b1, beats[idx*32 +: 32]});
            @(negedge clk);
            chk("rready_in_rdata", {31'b0, RREADY}, 32'd1);
            @(posedge clk); #1;
            if (vpat[s]) begin
                if (idx == rlast_idx || idx == 3) done = 1'b1;
                idx++;
                if (idx == rst_after) begin
                    RVALID = 1'b0; RLAST = 1'b0; active = 1'b0;
                    rst = 1'b1;
                    #1;
                    chk("async_rst_handshakes", {26'b0, ARVALID, AWVALID, WVALID, RREADY,
                        BREADY, mem_wait}, 32'd0);
                    chk("async_rst_mem_out", mem_out, 32'd0);
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    done = 1'b1;
                end
            end
        end
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        active = 1'b0;
        idle_check("idle_after_read");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [3:0] estrb, input logic [31:0] ewdata);
        int last;
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        issue(1'b1, a, d, t);
        for (int c = 0; c <= last; c++) begin
            AWREADY = (c == aw_dly);
            WREADY  = (c == w_dly);
            @(negedge clk);
            chk("awvalid", {31'b0, AWVALID}, {31'b0, c <= aw_dly});
            chk("wvalid", {31'b0, WVALID}, {31'b0, c <= w_dly});
            if (c == aw_dly) begin
                chk("awaddr", AWADDR, a);
                chk("aw_len_size_burst", {23'b0, AWLEN, AWSIZE, AWBURST},
                    {23'b0, 4'd0, 3'b010, 2'b01});
            end
            if (c == w_dly) begin
                chk("wstrb", {28'b0, WSTRB}, {28'b0, estrb});
                chk("wdata", WDATA, ewdata);
                chk("wlast", {31'b0, WLAST}, 32'd1);
            end
            @(posedge clk); #1;
        end
        AWREADY = 1'b0; WREADY = 1'b0;
        for (int b = 0; b <= b_dly; b++) begin
            BVALID = (b == b_dly);
            BRESP  = 2'b10;
            if (b == b_dly) sb.push_back('{1'b0, 32'h0});
            @(negedge clk);
            chk("bready", {31'b0, BREADY}, 32'd1);
            @(posedge clk); #1;
        end
        BVALID = 1'b0; BRESP = 2'b00;
        active = 1'b0;
        idle_check("idle_after_write");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_in = '0; mem_type = CACHE_WORD;
        ARREADY = 1'b0; RID = 4'h0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = 4'h0; BRESP = 2'b00; BVALID = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_handshakes", {26'b0, ARVALID, AWVALID, WVALID, RREADY, BREADY, mem_wait},
            32'd0);
        chk("reset_mem_out", mem_out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Line read, ARREADY after 2 cycles, back-to-back beats with RLAST on the fourth.
        do_read(32'h0000_1238, 2, 1'b0, 16'h000F, 4,
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 3, -1);
        // Gapped beats: beat, 2 idle, beat, beat, 1 idle, beat.
        do_read(32'h0000_4000, 0, 1'b0, 16'h0059, 7,
                {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 3, -1);
        // Byte write, AWREADY first cycle, WREADY third cycle.
        do_write(32'h0000_2003, 32'h0000_005A, CACHE_BYTE, 0, 2, 0, 4'b1000, 32'h5A5A_5A5A);
        // Halfword write, both ready at once, B after one wait cycle.
        do_write(32'h0000_2002, 32'h0000_BEEF, CACHE_HWORD, 0, 0, 1, 4'b1100, 32'hBEEF_BEEF);
        // Word write, WREADY before AWREADY.
        do_write(32'h0000_3004, 32'h1234_5678, CACHE_WORD, 2, 0, 0, 4'b1111, 32'h1234_5678);
        // Unsigned byte at offset 1.
        do_write(32'h0000_5001, 32'hABCD_EF12, CACHE_BYTE_U, 1, 1, 0, 4'b0010, 32'h1212_1212);
        // Unsigned halfword at offset 0.
        do_write(32'h0000_5000, 32'h0000_C0DE, CACHE_HWORD_U, 0, 1, 0, 4'b0011, 32'hC0DE_C0DE);
        // Reset after the second beat, then a clean read.
        do_read(32'h0000_6010, 1, 1'b0, 16'h000F, 4,
                {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 3, 2);
        do_read(32'h0000_6020, 0, 1'b0, 16'h000F, 4,
                {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 3, -1);
        // Early RLAST on beat 2: only two beats delivered.
        do_read(32'h0000_7000, 0, 1'b0, 16'h000F, 4,
                {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1, -1);
        // Stray RVALID during address phase, no RLAST: exit on the fourth beat count.
        do_read(32'h0000_800C, 2, 1'b1, 16'h001F, 5,
                {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 9, -1);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
